// File: rtl/mem_bridge_seq.sv
// Clocked bridge between the CPU main bus and the memory data bus.
// Moves one word per request and sequences the memory strobes with programmable wait, hold and turnaround timing.
module mem_bridge_seq #(
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1,
    parameter int HOLD_CYCLES = 1,
    parameter int TURN_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              MemBridge_Assert,
    input  logic              MemBridge_Direction,
    input  logic [DATA_W-1:0] MainBus_in,
    output logic [DATA_W-1:0] MainBus_out,
    output logic              MainBus_oe,
    input  logic [DATA_W-1:0] MEMDATA_in,
    output logic [DATA_W-1:0] MEMDATA_out,
    output logic              MEMDATA_oe,
    output logic              MEM_OE_n,
    output logic              MEM_WE_n,
    output logic              Busy,
    output logic              Done
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LD = CNT_W'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TURN,
        S_ACCESS,
        S_HOLD,
        S_DRIVE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_dir;
    logic              r_last_dir;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              w_cnt_zero;
    logic              w_accept;
    logic              w_capture;
    logic              w_done;

    assign w_cnt_zero = (r_cnt == '0);
    assign w_accept   = (r_state == S_IDLE) && MemBridge_Assert;
    assign w_capture  = (r_state == S_ACCESS) && w_cnt_zero && !r_dir;
    assign w_done     = ((r_state == S_HOLD) && w_cnt_zero) || (r_state == S_DRIVE);

    // Each phase loads its length minus one into a shared down-counter; zero marks the phase's last cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path through the case can infer a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (MemBridge_Assert) begin
                    if (MemBridge_Direction && !r_last_dir && (TURN_CYCLES > 0)) begin
                        w_state_nxt = S_TURN;
                        w_cnt_nxt   = TURN_LD;
                    end else begin
                        w_state_nxt = S_ACCESS;
                        w_cnt_nxt   = WAIT_LD;
                    end
                end
            end
            S_TURN: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_ACCESS;
                    w_cnt_nxt   = WAIT_LD;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_ACCESS: begin
                if (w_cnt_zero) begin
                    if (r_dir) begin
                        w_state_nxt = S_HOLD;
                        w_cnt_nxt   = HOLD_LD;
                    end else begin
                        w_state_nxt = S_DRIVE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_DRIVE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_dir      <= 1'b0;
            r_last_dir <= 1'b0;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else begin
            if (w_accept) begin
                r_dir <= MemBridge_Direction;
                if (MemBridge_Direction) begin
                    r_wdata <= MainBus_in;
                end
            end
            if (w_capture) begin
                r_rdata <= MEMDATA_in;
            end
            if (w_done) begin
                r_last_dir <= r_dir;
            end
        end
    end

    // Outputs decode only state and registers, so reset clears them asynchronously and no input reaches an output.
    assign Busy        = (r_state != S_IDLE);
    assign Done        = w_done;
    assign MainBus_oe  = (r_state == S_DRIVE);
    assign MainBus_out = r_rdata;
    assign MEMDATA_oe  = r_dir && ((r_state == S_ACCESS) || (r_state == S_HOLD));
    assign MEMDATA_out = r_wdata;
    assign MEM_WE_n    = !((r_state == S_ACCESS) && r_dir);
    assign MEM_OE_n    = !((r_state == S_ACCESS) && !r_dir);

endmodule

// File: tb/tb_mem_bridge_seq.sv
// Directed bench for mem_bridge_seq: three parameter sets share one clock and reset.
// Status vectors are packed as {Busy, Done, MainBus_oe, MEMDATA_oe, MEM_OE_n, MEM_WE_n}.
module tb_mem_bridge_seq;

    localparam logic [5:0] ST_IDLE  = 6'b000011;
    localparam logic [5:0] ST_TURN  = 6'b100011;
    localparam logic [5:0] ST_WACC  = 6'b100110;
    localparam logic [5:0] ST_HOLD  = 6'b100111;
    localparam logic [5:0] ST_HDONE = 6'b110111;
    localparam logic [5:0] ST_RACC  = 6'b100001;
    localparam logic [5:0] ST_DRIVE = 6'b111011;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic       a_assert, a_dir, a_mb_oe, a_md_oe, a_oe_n, a_we_n, a_busy, a_done;
    logic [7:0] a_mb_in, a_mb_out, a_md_in, a_md_out;
    logic [5:0] a_stat;
    assign a_stat = {a_busy, a_done, a_mb_oe, a_md_oe, a_oe_n, a_we_n};

    mem_bridge_seq dut_a (
        .CLK(clk), .RST_n(rst_n),
        .MemBridge_Assert(a_assert), .MemBridge_Direction(a_dir),
        .MainBus_in(a_mb_in), .MainBus_out(a_mb_out), .MainBus_oe(a_mb_oe),
        .MEMDATA_in(a_md_in), .MEMDATA_out(a_md_out), .MEMDATA_oe(a_md_oe),
        .MEM_OE_n(a_oe_n), .MEM_WE_n(a_we_n), .Busy(a_busy), .Done(a_done)
    );

    // Instance B: three wait cycles
    logic       b_assert, b_dir, b_mb_oe, b_md_oe, b_oe_n, b_we_n, b_busy, b_done;
    logic [7:0] b_mb_in, b_mb_out, b_md_in, b_md_out;
    logic [5:0] b_stat;
    assign b_stat = {b_busy, b_done, b_mb_oe, b_md_oe, b_oe_n, b_we_n};

    mem_bridge_seq #(.WAIT_CYCLES(3)) dut_b (
        .CLK(clk), .RST_n(rst_n),
        .MemBridge_Assert(b_assert), .MemBridge_Direction(b_dir),
        .MainBus_in(b_mb_in), .MainBus_out(b_mb_out), .MainBus_oe(b_mb_oe),
        .MEMDATA_in(b_md_in), .MEMDATA_out(b_md_out), .MEMDATA_oe(b_md_oe),
        .MEM_OE_n(b_oe_n), .MEM_WE_n(b_we_n), .Busy(b_busy), .Done(b_done)
    );

    // Instance C: 16-bit, no turnaround, two hold cycles
    logic        c_assert, c_dir, c_mb_oe, c_md_oe, c_oe_n, c_we_n, c_busy, c_done;
    logic [15:0] c_mb_in, c_mb_out, c_md_in, c_md_out;
    logic [5:0]  c_stat;
    assign c_stat = {c_busy, c_done, c_mb_oe, c_md_oe, c_oe_n, c_we_n};

    mem_bridge_seq #(.DATA_W(16), .TURN_CYCLES(0), .HOLD_CYCLES(2)) dut_c (
        .CLK(clk), .RST_n(rst_n),
        .MemBridge_Assert(c_assert), .MemBridge_Direction(c_dir),
        .MainBus_in(c_mb_in), .MainBus_out(c_mb_out), .MainBus_oe(c_mb_oe),
        .MEMDATA_in(c_md_in), .MEMDATA_out(c_md_out), .MEMDATA_oe(c_md_oe),
        .MEM_OE_n(c_oe_n), .MEM_WE_n(c_we_n), .Busy(c_busy), .Done(c_done)
    );

    int n_checks = 0;
    int n_errors = 0;
    int done_a   = 0;
    int inv_err  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus-safety invariants and Done pulse counting, sampled mid-cycle.
    always @(negedge clk) begin
        if (a_done === 1'b1) done_a++;
        if ((a_mb_oe && a_md_oe) || (!a_oe_n && !a_we_n) || (a_md_oe && !a_oe_n)) inv_err++;
        if ((b_mb_oe && b_md_oe) || (!b_oe_n && !b_we_n) || (b_md_oe && !b_oe_n)) inv_err++;
        if ((c_mb_oe && c_md_oe) || (!c_oe_n && !c_we_n) || (c_md_oe && !c_oe_n)) inv_err++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [3:0] b2b_dir = 4'b1011;
    int exp_lat[4]  = '{3, 3, 3, 4};
    int exp_turn[4] = '{0, 0, 0, 1};

    initial begin
        int idle_bad, lat, turns, idx, gap_err, d0;
        logic prev_done;

        rst_n = 1'b1;
        {a_assert, a_dir, a_mb_in, a_md_in} = '0;
        {b_assert, b_dir, b_mb_in, b_md_in} = '0;
        {c_assert, c_dir, c_mb_in, c_md_in} = '0;

        // Reset asserted between edges must clear outputs without a clock
        #3 rst_n = 1'b0;
        #1;
        check("rst_a_stat", a_stat, ST_IDLE);
        check("rst_a_mbout", a_mb_out, 0);
        check("rst_a_mdout", a_md_out, 0);
        check("rst_b_stat", b_stat, ST_IDLE);
        check("rst_c_stat", c_stat, ST_IDLE);
        tick();
        @(posedge clk);
        #1 rst_n = 1'b1;

        idle_bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (a_stat !== ST_IDLE || b_stat !== ST_IDLE || c_stat !== ST_IDLE) idle_bad++;
        end
        check("idle20", idle_bad, 0);

        // First write after reset goes through one turnaround cycle
        a_assert = 1'b1; a_dir = 1'b1; a_mb_in = 8'hA5;
        tick();
        a_assert = 1'b0;
        check("w1_turn", a_stat, ST_TURN);
        tick();
        check("w1_acc1", a_stat, ST_WACC);
        check("w1_data1", a_md_out, 8'hA5);
        tick();
        check("w1_acc2", a_stat, ST_WACC);
        tick();
        check("w1_hold", a_stat, ST_HDONE);
        check("w1_hdata", a_md_out, 8'hA5);
        tick();
        check("w1_idle", a_stat, ST_IDLE);

        // Read with three wait cycles; data changes right after the capture edge
        b_assert = 1'b1; b_dir = 1'b0; b_md_in = 8'h3C;
        tick();
        b_assert = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("r_acc", b_stat, ST_RACC);
            tick();
        end
        b_md_in = 8'hFF;
        check("r_drive", b_stat, ST_DRIVE);
        check("r_data", b_mb_out, 8'h3C);
        tick();
        check("r_idle", b_stat, ST_IDLE);
        check("r_keep", b_mb_out, 8'h3C);

        // Back-to-back W, W, R, W with Assert held high
        d0 = done_a; idx = 0; lat = 0; turns = 0; gap_err = 0; prev_done = 1'b0;
        a_md_in = 8'h5A; a_mb_in = 8'h10; a_dir = b2b_dir[0]; a_assert = 1'b1;
        for (int cyc = 0; cyc < 80 && idx < 4; cyc++) begin
            tick();
            if (a_busy) lat++;
            if (a_busy && !a_done && a_we_n && a_oe_n && !a_md_oe && !a_mb_oe) turns++;
            if (prev_done && a_busy) gap_err++;
            prev_done = a_done;
            if (a_done) begin
                check("b2b_lat", lat, exp_lat[idx]);
                check("b2b_turn", turns, exp_turn[idx]);
                if (idx == 2) check("b2b_rdata", a_mb_out, 8'h5A);
                idx++;
                lat = 0; turns = 0;
                if (idx < 4) begin
                    a_dir   = b2b_dir[idx];
                    a_mb_in = a_mb_in + 8'h11;
                end else begin
                    a_assert = 1'b0;
                end
            end
        end
        check("b2b_count", idx, 4);
        tick();
        if (prev_done && a_busy) gap_err++;
        check("b2b_gap", gap_err, 0);
        check("b2b_dones", done_a - d0, 4);

        // Abort during the second access cycle of a write
        a_assert = 1'b1; a_dir = 1'b1; a_mb_in = 8'hC3;
        tick();
        check("ab_acc1", a_stat, ST_WACC);
        tick();
        a_assert = 1'b0;
        check("ab_acc2", a_stat, ST_WACC);
        #2 rst_n = 1'b0;
        #1;
        check("ab_stat", a_stat, ST_IDLE);
        check("ab_mdout", a_md_out, 0);
        d0 = done_a;
        tick();
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        tick();
        check("ab_nodone", done_a - d0, 0);
        a_assert = 1'b1; a_dir = 1'b1; a_mb_in = 8'h77;
        tick();
        a_assert = 1'b0;
        check("ab_turn", a_stat, ST_TURN);
        tick();
        tick();
        tick();
        check("ab_hold", a_stat, ST_HDONE);
        check("ab_data", a_md_out, 8'h77);
        tick();

        // Wide instance: read, then write with no turnaround and two hold cycles
        c_assert = 1'b1; c_dir = 1'b0; c_md_in = 16'h1234;
        tick();
        c_assert = 1'b0;
        check("c_racc", c_stat, ST_RACC);
        tick();
        tick();
        check("c_drive", c_stat, ST_DRIVE);
        check("c_rdata", c_mb_out, 16'h1234);
        tick();
        check("c_idle1", c_stat, ST_IDLE);
        c_assert = 1'b1; c_dir = 1'b1; c_mb_in = 16'hBEEF;
        tick();
        check("c_wacc1", c_stat, ST_WACC);
        check("c_wdata1", c_md_out, 16'hBEEF);
        c_dir = 1'b0; c_mb_in = 16'h1111;
        tick();
        c_assert = 1'b0;
        check("c_wacc2", c_stat, ST_WACC);
        tick();
        c_assert = 1'b1;
        check("c_hold1", c_stat, ST_HOLD);
        check("c_hdata1", c_md_out, 16'hBEEF);
        tick();
        c_assert = 1'b0;
        check("c_hold2", c_stat, ST_HDONE);
        check("c_hdata2", c_md_out, 16'hBEEF);
        tick();
        check("c_idle2", c_stat, ST_IDLE);
        tick();
        check("c_idle3", c_stat, ST_IDLE);
        check("c_mbkeep", c_mb_out, 16'h1234);

        check("invariants", inv_err, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
